// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg
// Shared definitions for the serial memory bus, used by both master and slave
// so that the control frame has exactly one definition.
// Contents:
//   START_PATTERN  - three-bit frame preamble
//   slave_state_t  - slave transaction states
//   frame_* funcs  - bit offsets of each frame field, given the ID/address widths
// Frame layout, MSB first: START[3] | ID[id_w] | RW | BURST | ADDR[addr_w]
package serial_bus_pkg;

  localparam int START_WIDTH = 3;
  localparam logic [START_WIDTH-1:0] START_PATTERN = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    DECODE,
    RD_FETCH,
    RD_SHIFT,
    WR_SHIFT
  } slave_state_t;

  function automatic int frame_len(input int id_w, input int addr_w);
    return START_WIDTH + id_w + 2 + addr_w;
  endfunction

  function automatic int frame_addr_lsb();
    return 0;
  endfunction

  function automatic int frame_burst_pos(input int addr_w);
    return addr_w;
  endfunction

  function automatic int frame_rw_pos(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int frame_id_lsb(input int addr_w);
    return addr_w + 2;
  endfunction

  function automatic int frame_start_lsb(input int id_w, input int addr_w);
    return addr_w + 2 + id_w;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// slave_mem
// Single-port synchronous RAM, DATA_WIDTH x ADDR_DEPTH, with a registered read.
// Ports:
//   clk   - clock
//   addr  - word address (shared by read and write)
//   re    - read enable; rdata updates on the next edge
//   we    - write enable
//   wdata - write data
//   rdata - registered read data (holds its value while re=0)
// MEM_INIT_FILE is accepted for interface compatibility; no file is loaded.
module slave_mem #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_DEPTH    = 2000,
  parameter int    ADDR_WIDTH    = 11,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/serial_mem_slave.sv
// serial_mem_slave
// Serial-bus memory slave: decodes a serial control frame, then runs single or
// burst read/write transfers over 1-bit data lines with a valid/ready handshake.
// Ports:
//   clk     - clock, all logic on posedge
//   rstN    - synchronous reset, active HIGH (name inherited from the codebase)
//   control - serial control frame in, MSB first
//   wD      - serial write data in, MSB first
//   valid   - master beat valid (write: wD valid, read: master takes rD)
//   last    - burst terminator, looked at only on a word's final bit beat
//   rD      - serial read data out, MSB first
//   ready   - slave beat ready (write: wD accepted, read: rD valid)
//   err     - current transaction addressed beyond ADDR_DEPTH
module serial_mem_slave
  import serial_bus_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_DEPTH    = 2000,
  parameter int    SLAVES        = 3,
  parameter int    SLAVE_ID      = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready,
  output logic err
);

  localparam int S_ID_WIDTH = $clog2(SLAVES + 1);
  localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH);
  localparam int CTRL_LEN   = frame_len(S_ID_WIDTH, ADDR_WIDTH);
  localparam int CNT_W      = $clog2(CTRL_LEN);
  localparam int BIT_W      = $clog2(DATA_WIDTH);

  localparam int ADDR_LSB  = frame_addr_lsb();
  localparam int BURST_POS = frame_burst_pos(ADDR_WIDTH);
  localparam int RW_POS    = frame_rw_pos(ADDR_WIDTH);
  localparam int ID_LSB    = frame_id_lsb(ADDR_WIDTH);
  localparam int START_LSB = frame_start_lsb(S_ID_WIDTH, ADDR_WIDTH);

  localparam logic [S_ID_WIDTH-1:0] MY_ID      = S_ID_WIDTH'(SLAVE_ID);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(ADDR_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(ADDR_DEPTH);
  localparam logic [CNT_W-1:0]      FRAME_LAST = CNT_W'(CTRL_LEN - 1);
  localparam logic [BIT_W-1:0]      WORD_LAST  = BIT_W'(DATA_WIDTH - 1);

  slave_state_t state_reg, state_next;
  logic [CTRL_LEN-1:0]   frame_reg;
  logic [CNT_W-1:0]      frame_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  burst_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] buf_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Decoded view of the fully shifted frame (meaningful in DECODE).
  logic [START_WIDTH-1:0] f_start;
  logic [S_ID_WIDTH-1:0]  f_id;
  logic                   f_rw, f_burst, f_match, f_oor;
  logic [ADDR_WIDTH-1:0]  f_addr;

  assign f_start = frame_reg[START_LSB +: START_WIDTH];
  assign f_id    = frame_reg[ID_LSB +: S_ID_WIDTH];
  assign f_rw    = frame_reg[RW_POS];
  assign f_burst = frame_reg[BURST_POS];
  assign f_addr  = frame_reg[ADDR_LSB +: ADDR_WIDTH];
  assign f_match = (f_start == START_PATTERN) && (f_id == MY_ID);
  assign f_oor   = {1'b0, f_addr} >= DEPTH_EXT;

  logic                  shifting, beat, word_done, cont;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign shifting  = (state_reg == RD_SHIFT) || (state_reg == WR_SHIFT);
  assign beat      = shifting && valid;
  assign word_done = beat && (bit_cnt_reg == WORD_LAST);
  assign cont      = burst_reg && !last;
  assign next_addr = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
  assign err       = err_reg;

  slave_mem #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_DEPTH   (ADDR_DEPTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MEM_INIT_FILE(MEM_INIT_FILE)
  ) u_mem (
    .clk  (clk),
    .addr (mem_addr),
    .re   (mem_re),
    .we   (mem_we),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    rD         = 1'b0;
    mem_addr   = addr_reg;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = {buf_reg[DATA_WIDTH-2:0], wD};
    case (state_reg)
      IDLE: if (control) state_next = CONFIG;
      CONFIG: if (frame_cnt_reg == FRAME_LAST) state_next = DECODE;
      DECODE: begin
        if (!f_match) begin
          state_next = IDLE;
        end else begin
          state_next = f_rw ? WR_SHIFT : RD_FETCH;
          // Issue the first read now so the word is waiting at the end of RD_FETCH.
          mem_addr = f_addr;
          mem_re   = !f_rw && !f_oor;
        end
      end
      RD_FETCH: state_next = RD_SHIFT;
      RD_SHIFT: begin
        ready = 1'b1;
        rD    = buf_reg[DATA_WIDTH-1];
        // Prefetch: the RAM output register holds the following word while
        // this one shifts out. An out-of-range stream only ever reads as 0.
        mem_addr = next_addr;
        mem_re   = !err_reg;
        if (word_done && !cont) state_next = IDLE;
      end
      WR_SHIFT: begin
        ready  = 1'b1;
        mem_we = word_done && !err_reg;
        if (word_done && !cont) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_reg     <= IDLE;
      frame_reg     <= '0;
      frame_cnt_reg <= '0;
      addr_reg      <= '0;
      burst_reg     <= 1'b0;
      err_reg       <= 1'b0;
      buf_reg       <= '0;
      bit_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (control) begin
            frame_reg     <= {{(CTRL_LEN-1){1'b0}}, 1'b1};
            frame_cnt_reg <= CNT_W'(1);
          end
        end
        CONFIG: begin
          frame_reg     <= {frame_reg[CTRL_LEN-2:0], control};
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
        DECODE: begin
          addr_reg    <= f_addr;
          burst_reg   <= f_burst;
          err_reg     <= f_match && f_oor;
          bit_cnt_reg <= '0;
        end
        RD_FETCH: buf_reg <= err_reg ? '0 : mem_rdata;
        RD_SHIFT, WR_SHIFT: begin
          if (beat) begin
            bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
            if (state_reg == WR_SHIFT) buf_reg <= {buf_reg[DATA_WIDTH-2:0], wD};
            else if (word_done)        buf_reg <= err_reg ? '0 : mem_rdata;
            else                       buf_reg <= buf_reg << 1;
            if (word_done) begin
              if (cont) begin
                addr_reg <= next_addr;
                if (addr_reg == LAST_ADDR) err_reg <= 1'b0;
              end else begin
                err_reg <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_slave.sv
// Testbench for serial_mem_slave: directed and randomized transactions, a
// word-level memory model, and a per-beat scoreboard checked by a monitor.
module tb_serial_mem_slave;
  localparam int DW    = 32;
  localparam int DEPTH = 2000;
  localparam int AW    = 11;
  localparam int IDW   = 2;
  localparam int CLEN  = 3 + IDW + 2 + AW;

  logic clk = 1'b0;
  logic rstN, control, wD, valid, last;
  logic rD, ready, err;

  always #5 clk = ~clk;

  serial_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH), .SLAVES(3), .SLAVE_ID(1), .MEM_INIT_FILE("")
  ) dut (
    .clk(clk), .rstN(rstN), .control(control), .wD(wD), .valid(valid), .last(last),
    .rD(rD), .ready(ready), .err(err)
  );

  typedef struct packed {
    logic chk_rd;
    logic rd;
    logic err;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW-1:0]   wfix_q[$];
  logic [DW-1:0]   model_mem [2048];
  bit              known [2048];
  int              chk_cnt = 0;
  int              pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // Monitor: every handshake beat consumes one scoreboard entry; while a read
  // is stalled the presented bit must already be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (ready && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_err", err, e.err);
        if (e.chk_rd) check("beat_rd", rD, e.rd);
      end
    end else if (ready && !valid && exp_q.size() > 0) begin
      if (exp_q[0].chk_rd) check("stall_rd_hold", rD, exp_q[0].rd);
    end
  end

  task automatic send_frame(input logic [2:0] st, input logic [IDW-1:0] id, input logic rw,
                            input logic burst, input logic [AW-1:0] addr);
    logic [CLEN-1:0] f;
    f = {st, id, rw, burst, addr};
    for (int i = CLEN - 1; i >= 0; i--) begin
      control = f[i];
      @(posedge clk); #1;
    end
    control = 1'b0;
  endtask

  task automatic reject_frame(input logic [2:0] st, input logic [IDW-1:0] id, input string tag);
    bit seen;
    seen = 1'b0;
    send_frame(st, id, 1'b0, 1'b0, 11'd5);
    for (int i = 0; i < 8; i++) begin
      if (ready || err) seen = 1'b1;
      @(posedge clk); #1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  // stall_mode: 0 none, 1 random, 2 hold valid low for 5 cycles at beat 3.
  // abort_at >= 0: pulse reset after that many beats (write abandoned).
  task automatic xfer(input bit rw, input bit burst, input int addr, input int nwords,
                      input int stall_mode, input int abort_at, input string tag);
    logic [DW-1:0] wdq[$];
    logic [DW-1:0] val;
    exp_t ent;
    int a, total, b, cyc, k, stall_left, w, bi;
    bit e, v, r;

    a = addr;
    e = (addr >= DEPTH);
    for (int n = 0; n < nwords; n++) begin
      if (rw) begin
        val = (wfix_q.size() > 0) ? wfix_q.pop_front() : DW'($urandom);
        wdq.push_back(val);
        if (!e && abort_at < 0) begin
          model_mem[a] = val;
          known[a] = 1'b1;
        end
        for (int i = DW - 1; i >= 0; i--) begin
          ent.chk_rd = 1'b0; ent.rd = 1'b0; ent.err = e;
          exp_q.push_back(ent);
        end
      end else begin
        val = e ? '0 : model_mem[a];
        for (int i = DW - 1; i >= 0; i--) begin
          ent.chk_rd = e || known[a]; ent.rd = val[i]; ent.err = e;
          exp_q.push_back(ent);
        end
      end
      if (a == DEPTH - 1) begin
        a = 0;
        e = 1'b0;
      end else begin
        a = (a + 1) % 2048;
      end
    end

    send_frame(3'b111, 2'd1, rw, burst, AW'(addr));
    k = 1;
    while (!ready && k < 10) begin
      control = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    control = 1'b0;
    check({tag, "_latency"}, k, rw ? 32'd2 : 32'd3);

    total = nwords * DW;
    b = 0;
    cyc = 0;
    stall_left = 5;
    while (b < total && cyc < total * 4 + 50) begin
      v = 1'b1;
      if (stall_mode == 1) v = ($urandom_range(0, 3) != 0);
      else if (stall_mode == 2 && b == 3 && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end
      w  = b / DW;
      bi = DW - 1 - (b % DW);
      valid = v;
      wD = rw ? wdq[w][bi] : 1'($urandom_range(0, 1));
      if (bi == 0) last = (b == total - 1) ? (burst ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      else         last = 1'($urandom_range(0, 1));
      control = 1'($urandom_range(0, 1));
      r = ready;
      @(posedge clk);
      if (v && r) b++;
      #1;
      cyc++;
      if (abort_at >= 0 && b == abort_at) break;
    end
    valid = 1'b0;
    last = 1'b0;
    control = 1'b0;

    if (abort_at >= 0) begin
      rstN = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rstN = 1'b0;
      check({tag, "_ready"}, ready, 32'd0);
      check({tag, "_err"}, err, 32'd0);
      check({tag, "_rd"}, rD, 32'd0);
    end else begin
      check({tag, "_beats"}, b, total);
      if (stall_mode == 0) check({tag, "_nogap"}, cyc, total);
      check({tag, "_idle_ready"}, ready, 32'd0);
      check({tag, "_idle_err"}, err, 32'd0);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int addr, nw, cat;
    bit rw, bst;
    rstN = 1'b1; control = 1'b0; wD = 1'b0; valid = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 32'd0);
    check("reset_err", err, 32'd0);
    check("reset_rd", rD, 32'd0);
    rstN = 1'b0;
    @(posedge clk); #1;

    // Preload 1990..1999 and 0..21 in one wrapping burst.
    xfer(1'b1, 1'b1, 1990, 32, 1, -1, "preload");

    wfix_q.push_back(32'hDEADBEEF);
    xfer(1'b1, 1'b0, 5, 1, 0, -1, "wr_single");
    xfer(1'b0, 1'b0, 5, 1, 0, -1, "rd_single");

    wfix_q.push_back(32'h11111111);
    wfix_q.push_back(32'h22222222);
    wfix_q.push_back(32'h33333333);
    xfer(1'b1, 1'b1, 10, 3, 0, -1, "wr_burst");
    xfer(1'b0, 1'b1, 10, 3, 0, -1, "rd_burst");

    xfer(1'b0, 1'b0, 5, 1, 2, -1, "rd_stall");

    reject_frame(3'b111, 2'd2, "id2_quiet");
    reject_frame(3'b101, 2'd1, "badstart_quiet");
    xfer(1'b0, 1'b0, 10, 1, 0, -1, "after_reject");

    xfer(1'b1, 1'b1, 1999, 2, 0, -1, "wrap_wr");
    xfer(1'b0, 1'b1, 1999, 2, 1, -1, "wrap_rd");

    xfer(1'b0, 1'b0, 2010, 1, 0, -1, "oor_rd");
    xfer(1'b1, 1'b0, 2010, 1, 0, -1, "oor_wr");
    xfer(1'b0, 1'b1, 1990, 12, 1, -1, "oor_after");

    xfer(1'b1, 1'b0, 5, 1, 0, 16, "rst_mid");
    xfer(1'b0, 1'b0, 5, 1, 0, -1, "rst_after");

    for (int t = 0; t < 25; t++) begin
      cat = $urandom_range(0, 4);
      if (cat == 0) addr = $urandom_range(2000, 2040);
      else begin
        addr = 1990 + $urandom_range(0, 31);
        if (addr >= DEPTH) addr = addr - DEPTH;
      end
      rw  = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      bst = (nw > 1) ? 1'b1 : 1'($urandom_range(0, 1));
      xfer(rw, bst, addr, nw, $urandom_range(0, 1), -1, "rand");
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
